// File: rtl/ps_readout_pkg.sv
// Shared types and helpers for the Parallel_Serial readout arbiter.
// Holds the FSM state encoding, default sizing, and the round-robin pick.
package ps_readout_pkg;

  localparam int          NCH_DEF        = 4;
  localparam int          FIFO_WIDTH_DEF = 36;
  localparam int          BURST_MAX_DEF  = 16;
  localparam int unsigned RR_MAX_CH      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // First set bit of mask strictly after ptr, wrapping nch-1 -> 0.
  // Returns ptr when the mask is empty; callers only use it with a candidate present.
  function automatic int unsigned rr_next(input logic [RR_MAX_CH-1:0] mask,
                                          input int unsigned ptr,
                                          input int unsigned nch);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_CH; k++) begin
      if (k <= nch) begin
        idx = ptr + k;
        if (idx >= nch) begin
          idx = idx - nch;
        end else begin
          idx = idx;
        end
        if (!found && mask[idx[4:0]]) begin
          pick  = idx;
          found = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ps_readout_arbiter_skid.sv
// Two-entry skid FIFO holding channel words that have been read but not yet
// forwarded downstream. The arbiter guarantees it is never pushed while full.
module ps_readout_arbiter_skid #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok_s;
  logic         pop_ok_s;

  assign push_ok_s = push && ((count_q != 2'd2) || pop);
  assign pop_ok_s  = pop && (count_q != 2'd0);
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; reset discards any held words
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps_readout_arbiter.sv
// Round-robin readout scheduler draining per-channel FIFOs into the single
// control-interface FIFO, tagging each word with its channel ID.
// Optional feature macro: ARB_STATS_EN (per-channel forwarded-word counters).
module ps_readout_arbiter
  import ps_readout_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int CH_W       = 2,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             ch_enable,
  input  logic [NCH-1:0]             ch_empty,
  input  logic [NCH*FIFO_WIDTH-1:0]  ch_q,
  output logic [NCH-1:0]             ch_rd_en,
  input  logic                       out_full,
  output logic                       out_wr_en,
  output logic [CH_W+FIFO_WIDTH-1:0] out_data,
  output logic                       busy,
  output logic [CH_W-1:0]            grant_id
`ifdef ARB_STATS_EN
  ,
  input  logic [CH_W-1:0]            stat_sel,
  input  logic                       stat_clr,
  output logic [31:0]                stat_cnt
`endif
);

  localparam int SKID_W = CH_W + FIFO_WIDTH;
  localparam int BC_W   = $clog2(BURST_MAX + 1);

  arb_state_e          state_q, state_d;
  logic [CH_W-1:0]     grant_id_q, grant_id_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                inflight_q;
  logic [CH_W-1:0]     inflight_ch_q;
  logic                out_wr_en_q;
  logic [SKID_W-1:0]   out_data_q;

  logic [NCH-1:0]      cand_s;
  logic [CH_W-1:0]     pick_s;
  logic [NCH-1:0]      ch_rd_en_s;
  logic                space_s;
  logic                burst_done_s;
  logic [1:0]          skid_count_s;
  logic [SKID_W-1:0]   skid_head_s;
  logic [SKID_W-1:0]   skid_push_data_s;
  logic                pop_s;

  assign cand_s  = ch_enable & ~ch_empty;
  assign pick_s  = CH_W'(rr_next(RR_MAX_CH'(cand_s), 32'(rr_ptr_q), 32'(NCH)));
  // Counting the in-flight read against the skid keeps a landing slot reserved for every issued read.
  assign space_s = ({1'b0, skid_count_s} + {2'b00, inflight_q}) < 3'd2;
  assign burst_done_s = ch_empty[grant_id_q] | ~ch_enable[grant_id_q]
                      | (burst_cnt_q == BC_W'(BURST_MAX));
  assign pop_s   = (skid_count_s != 2'd0) && !out_full;
  assign skid_push_data_s = {inflight_ch_q, ch_q[inflight_ch_q*FIFO_WIDTH +: FIFO_WIDTH]};

  assign ch_rd_en  = ch_rd_en_s;
  assign out_wr_en = out_wr_en_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_id_q;

  ps_readout_arbiter_skid #(.W(SKID_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (skid_push_data_s),
    .pop       (pop_s),
    .count     (skid_count_s),
    .head      (skid_head_s)
  );

  // Next-state and read-enable decode; reads are combinational so the live empty flag gates them
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    ch_rd_en_s  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|cand_s) begin
          grant_id_d  = pick_s;
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (burst_done_s) begin
          state_d = ST_DRAIN;
        end else if (space_s && !rst) begin
          ch_rd_en_s[grant_id_q] = 1'b1;
          burst_cnt_d            = burst_cnt_q + BC_W'(1);
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q) begin
          rr_ptr_d = grant_id_q;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and scheduling registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= CH_W'(NCH - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Read-latency tracking and registered downstream write port
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q    <= 1'b0;
      inflight_ch_q <= '0;
      out_wr_en_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      inflight_q    <= |ch_rd_en_s;
      inflight_ch_q <= grant_id_q;
      out_wr_en_q   <= pop_s;
      out_data_q    <= pop_s ? skid_head_s : out_data_q;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0]     stat_q [NCH];
  logic [31:0]     stat_cnt_q;
  logic [CH_W-1:0] pop_ch_s;

  assign pop_ch_s = skid_head_s[SKID_W-1 -: CH_W];
  assign stat_cnt = stat_cnt_q;

  // Saturating per-channel forwarded-word counters with registered readback
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < NCH; i++) begin
        stat_q[i] <= 32'd0;
      end
      stat_cnt_q <= 32'd0;
    end else begin
      if (pop_s && (stat_q[pop_ch_s] != 32'hFFFF_FFFF)) begin
        stat_q[pop_ch_s] <= stat_q[pop_ch_s] + 32'd1;
      end
      stat_cnt_q <= stat_q[stat_sel];
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ps_readout_arbiter.sv
// Self-checking bench for ps_readout_arbiter: channel FIFO models, a
// burst-level round-robin model and a per-channel data scoreboard.
module tb_ps_readout_arbiter;

  localparam int NCH  = 4;
  localparam int FW   = 36;
  localparam int CH_W = 2;
  localparam int BMAX = 16;
  localparam int OW   = CH_W + FW;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      ch_enable, ch_empty, ch_rd_en;
  logic [NCH*FW-1:0]   ch_q;
  logic                out_full, out_wr_en, busy;
  logic [OW-1:0]       out_data;
  logic [CH_W-1:0]     grant_id;
`ifdef ARB_STATS_EN
  logic [CH_W-1:0]     stat_sel;
  logic                stat_clr;
  logic [31:0]         stat_cnt;
`endif

  always #5 clk = ~clk;

  ps_readout_arbiter #(.NCH(NCH), .FIFO_WIDTH(FW), .CH_W(CH_W), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .ch_empty(ch_empty), .ch_q(ch_q),
    .ch_rd_en(ch_rd_en), .out_full(out_full), .out_wr_en(out_wr_en), .out_data(out_data),
    .busy(busy), .grant_id(grant_id)
`ifdef ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [FW-1:0] chan_q [NCH][$];
  logic [FW-1:0] exp_q  [NCH][$];
  int rd_total [NCH];
  int out_cnt  [NCH];
  int grant_log [$];
  int len_log   [$];

  int             model_ptr  = NCH - 1;
  bit             in_burst   = 1'b0;
  bit             prev_busy  = 1'b0;
  bit             prev_full  = 1'b0;
  bit             len_chk_en = 1'b1;
  int             exp_len, burst_rd, cur_grant;
  logic [NCH-1:0] cand_prev = '0;
  logic [NCH-1:0] oh_m;
  logic [CH_W-1:0] tag_m;
  logic [FW-1:0]  word_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first candidate after ptr, wrapping.
  function automatic int rr_model(input logic [NCH-1:0] cand, input int ptr);
    for (int k = 1; k <= NCH; k++) begin
      if (cand[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic update_empty();
    for (int c = 0; c < NCH; c++) ch_empty[c] = (chan_q[c].size() == 0);
  endtask

  task automatic load(input int c, input int n, input int tid);
    for (int k = 0; k < n; k++) chan_q[c].push_back({4'(c), 8'(tid), 24'(k + 1)});
    update_empty();
  endtask

  // One clock: sample read strobes mid-cycle, present read data after the edge.
  task automatic tick();
    logic [NCH-1:0] rd;
    @(negedge clk);
    rd = ch_rd_en;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (rd[c] && chan_q[c].size() > 0) ch_q[c*FW +: FW] = chan_q[c].pop_front();
    end
    update_empty();
  endtask

  task automatic clear_logs();
    for (int c = 0; c < NCH; c++) begin
      rd_total[c] = 0;
      out_cnt[c]  = 0;
    end
    grant_log.delete();
    len_log.delete();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_rst_busy"}, busy, 0);
    check({name, "_rst_wr"}, out_wr_en, 0);
    check({name, "_rst_data"}, out_data, 0);
    check({name, "_rst_grant"}, grant_id, 0);
    check({name, "_rst_rd"}, ch_rd_en, 0);
  endtask

  task automatic do_reset(input string name);
    for (int c = 0; c < NCH; c++) chan_q[c].delete();
    update_empty();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values(name);
    clear_logs();
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int cyc   = 0;
    while (quiet < 4 && cyc < 3000) begin
      tick();
      cyc++;
      if (((ch_enable & ~ch_empty) == '0) && !busy && !out_wr_en) quiet++;
      else quiet = 0;
    end
    check({name, "_done"}, quiet >= 4, 1);
  endtask

  // Compare process: protocol rules, burst-level model and data scoreboard.
  always @(negedge clk) begin
    if (busy === 1'b1 && !prev_busy) begin
      cur_grant = rr_model(cand_prev, model_ptr);
      check("grant_rr", grant_id, 64'(cur_grant));
      grant_log.push_back(int'(grant_id));
      in_burst = 1'b1;
      burst_rd = 0;
      exp_len  = (chan_q[grant_id].size() < BMAX) ? chan_q[grant_id].size() : BMAX;
    end
    if (ch_rd_en !== '0) begin
      oh_m = '0;
      oh_m[grant_id] = 1'b1;
      check("rd_onehot_grant", ch_rd_en, oh_m);
      check("rd_while_busy", busy, 1);
      check("rd_on_empty", ch_rd_en & ch_empty, 0);
      for (int c = 0; c < NCH; c++) begin
        if (ch_rd_en[c]) begin
          if (chan_q[c].size() > 0) exp_q[c].push_back(chan_q[c][0]);
          rd_total[c]++;
        end
      end
      burst_rd++;
    end
    if (out_wr_en === 1'b1) begin
      tag_m  = out_data[OW-1:FW];
      word_m = out_data[FW-1:0];
      check("wr_after_full", prev_full, 0);
      check("out_outstanding", exp_q[tag_m].size() != 0, 1);
      if (exp_q[tag_m].size() != 0) check("out_word", word_m, exp_q[tag_m].pop_front());
      out_cnt[tag_m]++;
    end
    if (busy === 1'b0 && prev_busy && in_burst) begin
      if (len_chk_en) check("burst_len", burst_rd, exp_len);
      len_log.push_back(burst_rd);
      model_ptr = cur_grant;
      in_burst  = 1'b0;
    end
    prev_busy = (busy === 1'b1);
    prev_full = out_full;
    cand_prev = ch_enable & ~ch_empty;
    if (rst) begin
      for (int c = 0; c < NCH; c++) exp_q[c].delete();
      in_burst  = 1'b0;
      prev_busy = 1'b0;
      model_ptr = NCH - 1;
    end
  end

  int exp_g [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
  int exp_l [12] = '{16, 16, 16, 16, 16, 16, 16, 16, 8, 8, 8, 8};
  int bound;

  initial begin
    rst = 1'b1;
    ch_enable = '1;
    ch_empty  = '1;
    ch_q      = '0;
    out_full  = 1'b0;
`ifdef ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    repeat (2) tick();

    // 1: single channel, five words
    do_reset("t1");
    load(0, 5, 1);
    wait_idle("t1");
    check("t1_out_ch0", out_cnt[0], 5);
    check("t1_out_others", out_cnt[1] + out_cnt[2] + out_cnt[3], 0);
    check("t1_n_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) check("t1_grant0", grant_log[0], 0);
    if (len_log.size() > 0) check("t1_len0", len_log[0], 5);

    // 2: all channels, 40 words each, BURST_MAX bursts
    do_reset("t2");
    for (int c = 0; c < NCH; c++) load(c, 40, 2);
    wait_idle("t2");
    for (int c = 0; c < NCH; c++) check($sformatf("t2_out_ch%0d", c), out_cnt[c], 40);
    check("t2_n_grants", grant_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < grant_log.size()) check($sformatf("t2_grant%0d", i), grant_log[i], exp_g[i]);
      if (i < len_log.size()) check($sformatf("t2_len%0d", i), len_log[i], exp_l[i]);
    end
`ifdef ARB_STATS_EN
    // 6: statistics readback and clear
    stat_sel = 2'd3;
    tick();
    check("t6_stat_ch3", stat_cnt, 40);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("t6_stat_clr", stat_cnt, 0);
`endif

    // 3: downstream full for 20 cycles
    do_reset("t3");
    out_full = 1'b1;
    load(1, 10, 3);
    repeat (20) tick();
    check("t3_reads_stalled", rd_total[1], 2);
    check("t3_no_writes", out_cnt[1], 0);
    out_full = 1'b0;
    check("t3_wr_same_cycle", out_wr_en, 0);
    tick();
    check("t3_wr_resume", out_wr_en, 1);
    wait_idle("t3");
    check("t3_out_ch1", out_cnt[1], 10);
    check("t3_rd_ch1", rd_total[1], 10);

    // 4: enable dropped mid-burst
    do_reset("t4");
    len_chk_en = 1'b0;
    load(2, 10, 4);
    load(3, 3, 4);
    bound = 0;
    while (rd_total[2] < 3 && bound < 200) begin
      tick();
      bound++;
    end
    check("t4_third_read_seen", rd_total[2] >= 3, 1);
    ch_enable[2] = 1'b0;
    wait_idle("t4");
    check("t4_ch2_reads_le4", rd_total[2] <= 4, 1);
    check("t4_ch2_no_loss", out_cnt[2], rd_total[2]);
    check("t4_out_ch3", out_cnt[3], 3);
    check("t4_n_grants", grant_log.size(), 2);
    if (grant_log.size() > 1) check("t4_grant_next", grant_log[1], 3);
    ch_enable  = '1;
    len_chk_en = 1'b1;

    // 5: reset pulsed in the middle of a burst
    do_reset("t5");
    load(0, 3, 5);
    load(2, 10, 5);
    bound = 0;
    while (rd_total[2] < 4 && bound < 200) begin
      tick();
      bound++;
    end
    check("t5_mid_burst", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("t5mid");
    clear_logs();
    load(0, 2, 6);
    wait_idle("t5");
    check("t5_n_grants", grant_log.size(), 2);
    if (grant_log.size() > 0) check("t5_first_grant", grant_log[0], 0);
    if (grant_log.size() > 1) check("t5_second_grant", grant_log[1], 2);
    check("t5_out_ch0", out_cnt[0], 2);
    check("t5_ch2_no_loss", out_cnt[2], rd_total[2]);
    check("t5_ch2_drained", chan_q[2].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
